// File: rtl/dc_pkg.sv
// Shared RV32I decode definitions: internal op codes, opcode/funct constants, immediate formats.
// The M-extension op codes are always present so encodings match across builds.
package dc_pkg;

  localparam int unsigned DC_XLEN   = 32;
  localparam int unsigned DC_PC_W   = 32;
  localparam int unsigned DC_REG_AW = 5;
  localparam int unsigned DC_OP_W   = 6;

  typedef enum logic [DC_OP_W-1:0] {
    OP_NOP, OP_ILLEGAL,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/instr_decode_stage_if.sv
// Handshake bundle around the decode stage: instruction-queue side (in_*) and dispatch side (out_*).
interface instr_decode_stage_if
  import dc_pkg::*;
#(
  parameter int unsigned XLEN   = DC_XLEN,
  parameter int unsigned PC_W   = DC_PC_W,
  parameter int unsigned REG_AW = DC_REG_AW,
  parameter int unsigned OP_W   = DC_OP_W
);
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [31:0]       in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [OP_W-1:0]   out_op;
  logic [REG_AW-1:0] out_rs1;
  logic [REG_AW-1:0] out_rs2;
  logic [REG_AW-1:0] out_rd;
  logic              out_use_rs1;
  logic              out_use_rs2;
  logic              out_use_rd;
  logic [XLEN-1:0]   out_imm;
  logic              out_illegal;

  // Environment side: feeds instructions, consumes decoded results.
  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_op, out_rs1, out_rs2, out_rd,
           out_use_rs1, out_use_rs2, out_use_rd, out_imm, out_illegal
  );

  // Decode stage side.
  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_op, out_rs1, out_rs2, out_rd,
           out_use_rs1, out_use_rs2, out_use_rd, out_imm, out_illegal
  );
endinterface

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator, sign-extended from instr[31] to XLEN.
// Takes instr[31:7] only; the opcode field never contributes to an immediate.
module imm_gen
  import dc_pkg::*;
#(
  parameter int unsigned XLEN = DC_XLEN
) (
  input  logic [31:7]     instr_i,
  input  imm_fmt_e        fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt_i)
      IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
      IMM_U:   imm32 = {instr_i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/instr_decode_stage.sv
// Registered RV32I decode stage with valid/ready handshake and flush for mispredict recovery.
// Define DECODER_RV32M_EN to decode the M extension; otherwise those encodings are illegal.
module instr_decode_stage
  import dc_pkg::*;
#(
  parameter int unsigned XLEN   = DC_XLEN,
  parameter int unsigned PC_W   = DC_PC_W,
  parameter int unsigned REG_AW = DC_REG_AW,
  parameter int unsigned OP_W   = DC_OP_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  instr_decode_stage_if.slave  bus
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rs1_f, rs2_f, rd_f;

  assign opc   = bus.in_instr[6:0];
  assign rd_f  = bus.in_instr[11:7];
  assign f3    = bus.in_instr[14:12];
  assign rs1_f = bus.in_instr[19:15];
  assign rs2_f = bus.in_instr[24:20];
  assign f7    = bus.in_instr[31:25];

  op_e               op_d, op_q;
  imm_fmt_e          fmt_c;
  logic              use_rs1_c, use_rs2_c, use_rd_c;
  logic              use_rs1_d, use_rs2_d, use_rd_d, illegal_d;
  logic [REG_AW-1:0] rs1_d, rs2_d, rd_d;
  logic [XLEN-1:0]   imm_d;

  logic              valid_d, valid_q;
  logic [PC_W-1:0]   pc_q;
  logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
  logic              use_rs1_q, use_rs2_q, use_rd_q, illegal_q;
  logic [XLEN-1:0]   imm_q;
  logic              in_ready_c, accept_c;

  // Field decode: anything not matched below stays OP_ILLEGAL with no register use.
  always_comb begin
    op_d      = OP_ILLEGAL;
    fmt_c     = IMM_NONE;
    use_rs1_c = 1'b0;
    use_rs2_c = 1'b0;
    use_rd_c  = 1'b0;
    case (opc)
      OPC_LUI:   begin op_d = OP_LUI;   use_rd_c = 1'b1; fmt_c = IMM_U; end
      OPC_AUIPC: begin op_d = OP_AUIPC; use_rd_c = 1'b1; fmt_c = IMM_U; end
      OPC_JAL:   begin op_d = OP_JAL;   use_rd_c = 1'b1; fmt_c = IMM_J; end
      OPC_JALR: begin
        if (f3 == 3'b000) begin
          op_d = OP_JALR; use_rs1_c = 1'b1; use_rd_c = 1'b1; fmt_c = IMM_I;
        end
      end
      OPC_BRANCH: begin
        case (f3)
          3'b000:  op_d = OP_BEQ;
          3'b001:  op_d = OP_BNE;
          3'b100:  op_d = OP_BLT;
          3'b101:  op_d = OP_BGE;
          3'b110:  op_d = OP_BLTU;
          3'b111:  op_d = OP_BGEU;
          default: op_d = OP_ILLEGAL;
        endcase
        if (op_d != OP_ILLEGAL) begin
          use_rs1_c = 1'b1; use_rs2_c = 1'b1; fmt_c = IMM_B;
        end
      end
      OPC_LOAD: begin
        case (f3)
          3'b000:  op_d = OP_LB;
          3'b001:  op_d = OP_LH;
          3'b010:  op_d = OP_LW;
          3'b100:  op_d = OP_LBU;
          3'b101:  op_d = OP_LHU;
          default: op_d = OP_ILLEGAL;
        endcase
        if (op_d != OP_ILLEGAL) begin
          use_rs1_c = 1'b1; use_rd_c = 1'b1; fmt_c = IMM_I;
        end
      end
      OPC_STORE: begin
        case (f3)
          3'b000:  op_d = OP_SB;
          3'b001:  op_d = OP_SH;
          3'b010:  op_d = OP_SW;
          default: op_d = OP_ILLEGAL;
        endcase
        if (op_d != OP_ILLEGAL) begin
          use_rs1_c = 1'b1; use_rs2_c = 1'b1; fmt_c = IMM_S;
        end
      end
      OPC_OP_IMM: begin
        case (f3)
          F3_ADD:  op_d = OP_ADDI;
          F3_SLT:  op_d = OP_SLTI;
          F3_SLTU: op_d = OP_SLTIU;
          F3_XOR:  op_d = OP_XORI;
          F3_OR:   op_d = OP_ORI;
          F3_AND:  op_d = OP_ANDI;
          F3_SLL:  op_d = (f7 == F7_BASE) ? OP_SLLI : OP_ILLEGAL;
          F3_SR:   op_d = (f7 == F7_BASE) ? OP_SRLI :
                          (f7 == F7_ALT)  ? OP_SRAI : OP_ILLEGAL;
          default: op_d = OP_ILLEGAL;
        endcase
        if (op_d != OP_ILLEGAL) begin
          use_rs1_c = 1'b1; use_rd_c = 1'b1; fmt_c = IMM_I;
        end
      end
      OPC_OP: begin
        case (f7)
          F7_BASE: begin
            case (f3)
              F3_ADD:  op_d = OP_ADD;
              F3_SLL:  op_d = OP_SLL;
              F3_SLT:  op_d = OP_SLT;
              F3_SLTU: op_d = OP_SLTU;
              F3_XOR:  op_d = OP_XOR;
              F3_SR:   op_d = OP_SRL;
              F3_OR:   op_d = OP_OR;
              default: op_d = OP_AND;
            endcase
          end
          F7_ALT: begin
            case (f3)
              F3_ADD:  op_d = OP_SUB;
              F3_SR:   op_d = OP_SRA;
              default: op_d = OP_ILLEGAL;
            endcase
          end
          F7_MULDIV: begin
`ifdef DECODER_RV32M_EN
            case (f3)
              3'b000:  op_d = OP_MUL;
              3'b001:  op_d = OP_MULH;
              3'b010:  op_d = OP_MULHSU;
              3'b011:  op_d = OP_MULHU;
              3'b100:  op_d = OP_DIV;
              3'b101:  op_d = OP_DIVU;
              3'b110:  op_d = OP_REM;
              default: op_d = OP_REMU;
            endcase
`else
            op_d = OP_ILLEGAL;
`endif
          end
          default: op_d = OP_ILLEGAL;
        endcase
        if (op_d != OP_ILLEGAL) begin
          use_rs1_c = 1'b1; use_rs2_c = 1'b1; use_rd_c = 1'b1;
        end
      end
      OPC_MISC_MEM: op_d = OP_NOP;
      default:      op_d = OP_ILLEGAL;
    endcase
  end

  // Unused indices read as 0; writes to x0 are dropped here rather than downstream.
  always_comb begin
    illegal_d = (op_d == OP_ILLEGAL);
    use_rs1_d = use_rs1_c;
    use_rs2_d = use_rs2_c;
    use_rd_d  = use_rd_c && (rd_f != 5'd0);
    rs1_d     = use_rs1_d ? REG_AW'(rs1_f) : '0;
    rs2_d     = use_rs2_d ? REG_AW'(rs2_f) : '0;
    rd_d      = use_rd_d  ? REG_AW'(rd_f)  : '0;
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i (bus.in_instr[31:7]),
    .fmt_i   (fmt_c),
    .imm_o   (imm_d)
  );

  // Handshake: flush has priority over both accept and fire.
  always_comb begin
    in_ready_c = !flush_i && (!valid_q || bus.out_ready);
    accept_c   = bus.in_valid && in_ready_c;
    valid_d    = valid_q;
    if (flush_i)                        valid_d = 1'b0;
    else if (accept_c)                  valid_d = 1'b1;
    else if (valid_q && bus.out_ready)  valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      op_q      <= OP_NOP;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      use_rs1_q <= 1'b0;
      use_rs2_q <= 1'b0;
      use_rd_q  <= 1'b0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (accept_c) begin
        pc_q      <= bus.in_pc;
        op_q      <= op_d;
        rs1_q     <= rs1_d;
        rs2_q     <= rs2_d;
        rd_q      <= rd_d;
        use_rs1_q <= use_rs1_d;
        use_rs2_q <= use_rs2_d;
        use_rd_q  <= use_rd_d;
        imm_q     <= imm_d;
        illegal_q <= illegal_d;
      end
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = valid_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_op      = OP_W'(op_q);
  assign bus.out_rs1     = rs1_q;
  assign bus.out_rs2     = rs2_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_use_rs1 = use_rs1_q;
  assign bus.out_use_rs2 = use_rs2_q;
  assign bus.out_use_rd  = use_rd_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_illegal = illegal_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: hand-derived expectations queued on accept, checked on fire.
// Expectations for the M encoding follow DECODER_RV32M_EN.
module tb_instr_decode_stage;
  import dc_pkg::*;

  typedef struct {
    logic [31:0] pc;
    op_e         op;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, ud;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  logic clk, rst, flush;
  instr_decode_stage_if bus ();

  instr_decode_stage dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t sb[$];
  exp_t pend;
  int   n_err  = 0;
  int   n_chk  = 0;
  int   pops   = 0;
  int   pops0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input op_e op, input int rs1, input int rs2, input int rd,
                              input logic u1, input logic u2, input logic ud,
                              input logic [31:0] imm, input logic ill);
    exp_t e;
    e.pc = '0; e.op = op; e.rs1 = 5'(rs1); e.rs2 = 5'(rs2); e.rd = 5'(rd);
    e.u1 = u1; e.u2 = u2; e.ud = ud; e.imm = imm; e.ill = ill;
    return e;
  endfunction

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    pops++;
    chk($sformatf("pc@%0h", e.pc),      32'(bus.out_pc),      e.pc);
    chk($sformatf("op@%0h", e.pc),      32'(bus.out_op),      32'(e.op));
    chk($sformatf("rs1@%0h", e.pc),     32'(bus.out_rs1),     32'(e.rs1));
    chk($sformatf("rs2@%0h", e.pc),     32'(bus.out_rs2),     32'(e.rs2));
    chk($sformatf("rd@%0h", e.pc),      32'(bus.out_rd),      32'(e.rd));
    chk($sformatf("use_rs1@%0h", e.pc), 32'(bus.out_use_rs1), 32'(e.u1));
    chk($sformatf("use_rs2@%0h", e.pc), 32'(bus.out_use_rs2), 32'(e.u2));
    chk($sformatf("use_rd@%0h", e.pc),  32'(bus.out_use_rd),  32'(e.ud));
    chk($sformatf("imm@%0h", e.pc),     32'(bus.out_imm),     e.imm);
    chk($sformatf("illegal@%0h", e.pc), 32'(bus.out_illegal), 32'(e.ill));
  endtask

  // One clock: observe at the falling edge, then return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (bus.out_valid && bus.out_ready && !flush) compare_out();
    else if (flush && bus.out_valid && sb.size() != 0) void'(sb.pop_front());
    if (bus.in_valid && bus.in_ready) sb.push_back(pend);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input exp_t e);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_instr = instr;
    pend         = e;
    pend.pc      = pc;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] instr, input exp_t e);
    drive(pc, instr, e);
    tick();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    tick();
  endtask

  exp_t e_mul;

  initial begin
`ifdef DECODER_RV32M_EN
    e_mul = mk(OP_MUL, 1, 2, 3, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
`else
    e_mul = mk(OP_ILLEGAL, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
`endif
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",   32'(bus.out_valid),   32'd0);
    chk("rst_op",      32'(bus.out_op),      32'(OP_NOP));
    chk("rst_pc",      32'(bus.out_pc),      32'd0);
    chk("rst_imm",     32'(bus.out_imm),     32'd0);
    chk("rst_rd",      32'(bus.out_rd),      32'd0);
    chk("rst_use_rd",  32'(bus.out_use_rd),  32'd0);
    chk("rst_illegal", 32'(bus.out_illegal), 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // Full-throughput stream of assorted formats.
    send(32'h100, 32'hFFF10093, mk(OP_ADDI, 2, 0, 1, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0));
    chk("latency_valid", 32'(bus.out_valid), 32'd1);
    send(32'h104, 32'h00322423, mk(OP_SW,    4, 3, 0, 1'b1, 1'b1, 1'b0, 32'h8,        1'b0));
    send(32'h108, 32'h123452B7, mk(OP_LUI,   0, 0, 5, 1'b0, 1'b0, 1'b1, 32'h12345000, 1'b0));
    send(32'h10C, 32'h00000013, mk(OP_ADDI,  0, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0));
    send(32'h110, 32'hFFFFFFFF, mk(OP_ILLEGAL, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,      1'b1));
    send(32'h114, 32'h022081B3, e_mul);
    send(32'h118, 32'h00629863, mk(OP_BNE,   5, 6, 0, 1'b1, 1'b1, 1'b0, 32'h10,       1'b0));
    send(32'h11C, 32'hFE000FE3, mk(OP_BEQ,   0, 0, 0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0));
    send(32'h120, 32'h001000EF, mk(OP_JAL,   0, 0, 1, 1'b0, 1'b0, 1'b1, 32'h800,      1'b0));
    send(32'h124, 32'hFFFFF517, mk(OP_AUIPC, 0, 0, 10, 1'b0, 1'b0, 1'b1, 32'hFFFFF000, 1'b0));
    send(32'h128, 32'h409403B3, mk(OP_SUB,   8, 9, 7, 1'b1, 1'b1, 1'b1, 32'h0,        1'b0));
    send(32'h12C, 32'h4030D093, mk(OP_SRAI,  1, 0, 1, 1'b1, 1'b0, 1'b1, 32'h403,      1'b0));
    send(32'h130, 32'h0FF0000F, mk(OP_NOP,   0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0));
    send(32'h134, 32'h40001033, mk(OP_ILLEGAL, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,      1'b1));
    idle();
    idle();
    chk("stream_drained", 32'(sb.size()), 32'd0);

    // Backpressure: hold for 3 cycles with a second instruction offered.
    bus.out_ready = 1'b0;
    send(32'h200, 32'hFF812303, mk(OP_LW, 2, 0, 6, 1'b1, 1'b0, 1'b1, 32'hFFFFFFF8, 1'b0));
    drive(32'h204, 32'h00000013, mk(OP_ADDI, 0, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_in_ready", 32'(bus.in_ready),  32'd0);
      chk("hold_valid",    32'(bus.out_valid), 32'd1);
      chk("hold_pc",       32'(bus.out_pc),    32'h200);
      chk("hold_op",       32'(bus.out_op),    32'(OP_LW));
      chk("hold_imm",      32'(bus.out_imm),   32'hFFFFFFF8);
    end
    pops0 = pops;
    bus.out_ready = 1'b1;
    tick();
    send(32'h208, 32'h00322423, mk(OP_SW,  4, 3, 0, 1'b1, 1'b1, 1'b0, 32'h8,        1'b0));
    send(32'h20C, 32'h123452B7, mk(OP_LUI, 0, 0, 5, 1'b0, 1'b0, 1'b1, 32'h12345000, 1'b0));
    send(32'h210, 32'hFFF10093, mk(OP_ADDI, 2, 0, 1, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0));
    idle();
    chk("release_pops", 32'(pops - pops0), 32'd5);
    chk("release_empty", 32'(sb.size()), 32'd0);

    // Flush kills the held entry and refuses the offered one.
    bus.out_ready = 1'b0;
    send(32'h300, 32'h409403B3, mk(OP_SUB, 8, 9, 7, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0));
    drive(32'h304, 32'h001000EF, mk(OP_JAL, 0, 0, 1, 1'b0, 1'b0, 1'b1, 32'h800, 1'b0));
    flush = 1'b1;
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_sb",    32'(sb.size()),     32'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("post_flush_accept", 32'(bus.out_valid), 32'd1);
    idle();

    // Asynchronous reset mid-stream, then accept on the first edge after release.
    bus.out_ready = 1'b0;
    send(32'h400, 32'hFFFFF517, mk(OP_AUIPC, 0, 0, 10, 1'b0, 1'b0, 1'b1, 32'hFFFFF000, 1'b0));
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_op",    32'(bus.out_op),    32'(OP_NOP));
    chk("async_rst_imm",   32'(bus.out_imm),   32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    send(32'h500, 32'h4030D093, mk(OP_SRAI, 1, 0, 1, 1'b1, 1'b0, 1'b1, 32'h403, 1'b0));
    chk("first_after_rst", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 4 && sb.size() != 0; i++) idle();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
